// File: rtl/uart_rx_reader.sv
// ---------------------------------------------------------------------------
// uart_rx_reader
//
// Purpose:
//   AXI4-Lite read-only master that polls the status register of an AXI UART
//   Lite and drains its RX FIFO one byte per read. Received bytes are packed
//   little-endian into 32-bit words. Each word goes into an internal FIFO
//   that the core reads.
//
// Ports:
//   clk, rstn          system clock (rising edge), async active-low reset
//   m_axi_ar*          read address channel (araddr, arvalid, arready)
//   m_axi_r*           read data channel (rdata, rresp, rvalid, rready)
//   re                 core read enable; pops one word when the buffer is not empty
//   dout               popped word, registered the cycle after an accepted re
//   empty              buffer holds no words
//   almost_full        count >= DEPTH-4
//   count              words currently buffered (0..DEPTH)
//   err                sticky; set by any SLVERR/DECERR response
//   state_dbg          current FSM state, for observation only
//
// Handshakes:
//   AXI channels use standard valid/ready. A transfer happens on a rising
//   edge where valid and ready are both high. Once arvalid is raised, it and
//   araddr stay stable until arready is seen. Only one read is outstanding
//   at any time. rready is high only while the FSM waits for a response.
// ---------------------------------------------------------------------------
module uart_rx_reader #(
    parameter logic [31:0] UART_BASE = 32'h0000_0000,
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [31:0]      m_axi_araddr,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    input  logic             re,
    output logic [31:0]      dout,
    output logic             empty,
    output logic             almost_full,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam int AW     = $clog2(DEPTH);
    localparam int AF_LVL = (DEPTH > 4) ? DEPTH - 4 : 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STAT_AR = 3'd1,
        STAT_R  = 3'd2,
        DATA_AR = 3'd3,
        DATA_R  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [23:0]       asm_q, asm_d;        // bytes 0..2 of the word in progress
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       dout_q, dout_d;
    logic [31:0]       mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic              has_room;
    logic [31:0]       push_word;

    // Only bit 0 of status, byte 0 of data and rresp[1] carry information.
    logic unused_ok;
    assign unused_ok = ^{m_axi_rresp[0], m_axi_rdata[31:8]};

    assign has_room  = (count_q != CNT_W'(DEPTH));
    // Lane 3 comes straight off the bus, so the word is complete on that handshake.
    assign push_word = {m_axi_rdata[7:0], asm_q};
    assign pop       = re && (count_q != '0);

    // ---------------- FSM next-state and AXI outputs ----------------
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        asm_d         = asm_q;
        byte_cnt_d    = byte_cnt_q;
        push          = 1'b0;
        m_axi_araddr  = 32'h0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (has_room) state_d = STAT_AR;
            end
            STAT_AR: begin
                m_axi_araddr  = UART_BASE + 32'd8;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = STAT_R;
            end
            STAT_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    // Room is re-checked here: a data read must always have space to land.
                    if (!m_axi_rresp[1] && m_axi_rdata[0] && has_room) state_d = DATA_AR;
                    else                                               state_d = IDLE;
                    if (m_axi_rresp[1]) err_d = 1'b1;
                end
            end
            DATA_AR: begin
                m_axi_araddr  = UART_BASE;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = DATA_R;
            end
            DATA_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    state_d = IDLE;
                    if (m_axi_rresp[1]) begin
                        err_d = 1'b1;   // byte dropped, lane position kept
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    asm_d[7:0]   = m_axi_rdata[7:0];
                            2'd1:    asm_d[15:8]  = m_axi_rdata[7:0];
                            2'd2:    asm_d[23:16] = m_axi_rdata[7:0];
                            default: push         = 1'b1;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Buffer bookkeeping ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
        end
    end

    // Storage needs no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign dout        = dout_q;
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_W'(AF_LVL));
    assign count       = count_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_reader.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_reader
//
// Bench for uart_rx_reader. A behavioural UART Lite slave serves the AXI
// reads. Its status bit 0 is high while its byte queue is non-empty. Test
// tasks queue bytes to the slave and push the words they expect into exp_q.
// Words popped from the DUT are compared against the front of exp_q.
// ---------------------------------------------------------------------------
module tb_uart_rx_reader;

    localparam logic [31:0] BASE  = 32'h4060_0000;
    localparam int          DEPTH = 16;
    localparam int          CNT_W = 5;

    logic             clk;
    logic             rstn;
    logic [31:0]      m_axi_araddr;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [31:0]      m_axi_rdata;
    logic [1:0]       m_axi_rresp;
    logic             m_axi_rvalid;
    logic             m_axi_rready;
    logic             re;
    logic [31:0]      dout;
    logic             empty;
    logic             almost_full;
    logic [CNT_W-1:0] count;
    logic             err;
    logic [2:0]       state_dbg;

    // Slave byte queue entries are {rresp, byte}.
    logic [9:0]  byte_q[$];
    logic [31:0] exp_q[$];
    int          ar_delay;
    bit          slave_en;
    int          stat_reads;
    int          data_reads;
    int          n_pass;
    int          n_total;

    uart_rx_reader #(.UART_BASE(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .re(re), .dout(dout), .empty(empty),
        .almost_full(almost_full), .count(count), .err(err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- UART Lite slave model ----------------
    initial begin : slave
        logic [31:0] a;
        logic [9:0]  v;
        forever begin
            @(posedge clk); #1;
            if (slave_en && rstn && m_axi_arvalid) begin
                a = m_axi_araddr;
                for (int i = 0; i < ar_delay; i++) begin
                    @(posedge clk); #1;
                    n_total++;
                    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== a)
                        $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 and %h",
                                 m_axi_arvalid, m_axi_araddr, a);
                    else n_pass++;
                end
                m_axi_arready = 1'b1;
                @(posedge clk); #1;
                m_axi_arready = 1'b0;
                if (a == BASE) begin
                    data_reads++;
                    if (byte_q.size() > 0) begin
                        v = byte_q.pop_front();
                        m_axi_rdata = {24'h0, v[7:0]};
                        m_axi_rresp = v[9:8];
                    end else begin
                        m_axi_rdata = 32'h0;
                        m_axi_rresp = 2'b00;
                    end
                end else begin
                    stat_reads++;
                    m_axi_rdata = (byte_q.size() > 0) ? 32'h1 : 32'h0;
                    m_axi_rresp = 2'b00;
                end
                m_axi_rvalid = 1'b1;
                @(posedge clk); #1;
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = 32'h0;
                m_axi_rresp  = 2'b00;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic queue_word(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        byte_q.push_back({2'b00, b0});
        byte_q.push_back({2'b00, b1});
        byte_q.push_back({2'b00, b2});
        byte_q.push_back({2'b00, b3});
        exp_q.push_back({b3, b2, b1, b0});
    endtask

    // Waits (at #1 after posedge) until the buffer is non-empty; returns 1 on timeout.
    task automatic wait_not_empty(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!empty) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Pops one word; on return dout holds the popped value.
    task automatic pop_word;
        re = 1'b1;
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [73:0] got, want;
        int          n;
        bit          seen;
        slave_en = 1'b0;
        rstn     = 1'b0;
        want = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            m_axi_arready = 1'($urandom_range(0, 1));
            m_axi_rvalid  = 1'($urandom_range(0, 1));
            m_axi_rdata   = $urandom;
            m_axi_rresp   = 2'($urandom_range(0, 3));
            re            = 1'($urandom_range(0, 1));
            got = {m_axi_arvalid, m_axi_rready, m_axi_araddr, dout, empty, almost_full, count, err};
            n_total++;
            if (got !== want) $display("FAIL reset_values: got %h, required %h", got, want);
            else n_pass++;
        end
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = 32'h0;
        m_axi_rresp   = 2'b00;
        re            = 1'b0;
        slave_en      = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        n_total++;
        if (m_axi_arvalid !== 1'b0) $display("FAIL arvalid_at_release: got %b, required 0", m_axi_arvalid);
        else n_pass++;
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (m_axi_arvalid === 1'b1) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
        n_total++;
        if (!seen || n > 2) $display("FAIL first_arvalid: seen=%0d after %0d cycles, required within 2", seen, n);
        else n_pass++;
        n_total++;
        if (m_axi_araddr !== BASE + 32'd8) $display("FAIL first_araddr: got %h, required %h", m_axi_araddr, BASE + 32'd8);
        else n_pass++;
    endtask

    task automatic test_no_data;
        int s0, d0;
        ar_delay = 0;
        s0 = stat_reads;
        d0 = data_reads;
        repeat (80) @(posedge clk);
        #1;
        n_total++;
        if (data_reads != d0) $display("FAIL no_data_reads: got %0d data reads, required 0", data_reads - d0);
        else n_pass++;
        n_total++;
        if (stat_reads - s0 < 5) $display("FAIL status_polling: got %0d status reads, required >= 5", stat_reads - s0);
        else n_pass++;
        n_total++;
        if (count !== 5'd0 || empty !== 1'b1) $display("FAIL no_data_count: count=%0d empty=%b, required 0 and 1", count, empty);
        else n_pass++;
    endtask

    task automatic test_single_word;
        bit          to;
        logic [31:0] last;
        ar_delay = 3;
        queue_word(8'h11, 8'h22, 8'h33, 8'h44);
        wait_not_empty(600, to);
        n_total++;
        if (to) $display("FAIL single_word_timeout: empty=%b, required 0", empty);
        else n_pass++;
        n_total++;
        if (count !== 5'd1) $display("FAIL single_word_count: got %0d, required 1", count);
        else n_pass++;
        pop_word();
        last = exp_q.pop_front();
        n_total++;
        if (dout !== last) $display("FAIL single_word_dout: got %h, required %h", dout, last);
        else n_pass++;
        n_total++;
        if (empty !== 1'b1 || count !== 5'd0) $display("FAIL single_word_drained: empty=%b count=%0d, required 1 and 0", empty, count);
        else n_pass++;
        // Read while empty: ignored, dout holds.
        pop_word();
        n_total++;
        if (dout !== last || count !== 5'd0) $display("FAIL re_when_empty: dout=%h count=%0d, required %h and 0", dout, count, last);
        else n_pass++;
    endtask

    task automatic test_fill;
        bit          full_seen, ar_seen, resumed;
        logic [31:0] w;
        int          exp_cnt;
        ar_delay = 0;
        for (int i = 0; i < DEPTH + 1; i++)
            queue_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        full_seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (count == 5'(DEPTH)) begin
                full_seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!full_seen || almost_full !== 1'b1) $display("FAIL fill_full: count=%0d almost_full=%b, required %0d and 1", count, almost_full, DEPTH);
        else n_pass++;
        ar_seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (m_axi_arvalid !== 1'b0 || state_dbg !== 3'd0) ar_seen = 1'b1;
        end
        n_total++;
        if (ar_seen) $display("FAIL fill_parked: arvalid or non-IDLE seen while full, required idle with arvalid 0");
        else n_pass++;
        n_total++;
        if (byte_q.size() != 4 || count !== 5'(DEPTH)) $display("FAIL fill_no_extra: slave bytes left %0d count=%0d, required 4 and %0d", byte_q.size(), count, DEPTH);
        else n_pass++;
        pop_word();
        w = exp_q.pop_front();
        n_total++;
        if (dout !== w || count !== 5'(DEPTH - 1)) $display("FAIL fill_pop_one: dout=%h count=%0d, required %h and %0d", dout, count, w, DEPTH - 1);
        else n_pass++;
        resumed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (m_axi_arvalid === 1'b1) begin
                resumed = 1'b1;
                break;
            end
        end
        n_total++;
        if (!resumed) $display("FAIL fill_resume: arvalid stayed 0, required polling to resume");
        else n_pass++;
        full_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (byte_q.size() == 0 && count == 5'(DEPTH)) begin
                full_seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!full_seen) $display("FAIL refill: count=%0d, required %0d", count, DEPTH);
        else n_pass++;
        exp_cnt = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            pop_word();
            exp_cnt--;
            w = exp_q.pop_front();
            n_total++;
            if (dout !== w || count !== 5'(exp_cnt) || almost_full !== (exp_cnt >= DEPTH - 4))
                $display("FAIL drain[%0d]: dout=%h count=%0d af=%b, required %h %0d %b",
                         i, dout, count, almost_full, w, exp_cnt, (exp_cnt >= DEPTH - 4));
            else n_pass++;
        end
    endtask

    task automatic test_error;
        bit          to;
        logic [31:0] w;
        ar_delay = 1;
        n_total++;
        if (err !== 1'b0) $display("FAIL err_clear_before: got %b, required 0", err);
        else n_pass++;
        byte_q.push_back({2'b00, 8'h5A});
        byte_q.push_back({2'b10, 8'h99});
        byte_q.push_back({2'b00, 8'hAA});
        byte_q.push_back({2'b00, 8'hBB});
        byte_q.push_back({2'b00, 8'hCC});
        exp_q.push_back(32'hCCBB_AA5A);
        wait_not_empty(600, to);
        n_total++;
        if (to || err !== 1'b1) $display("FAIL err_set: timeout=%0d err=%b, required 0 and 1", to, err);
        else n_pass++;
        pop_word();
        w = exp_q.pop_front();
        n_total++;
        if (dout !== w) $display("FAIL err_word: got %h, required %h", dout, w);
        else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_total++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b, required 1", err);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int          got;
        bit          popped;
        logic [31:0] w;
        ar_delay = 0;
        for (int i = 0; i < 3; i++)
            queue_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        got    = 0;
        popped = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (popped) begin
                w = exp_q.pop_front();
                got++;
                n_total++;
                if (dout !== w) $display("FAIL b2b_word[%0d]: got %h, required %h", got, dout, w);
                else n_pass++;
            end
            if (got == 3) begin
                re = 1'b0;
                break;
            end
            re     = !empty;
            popped = !empty;
        end
        re = 1'b0;
        n_total++;
        if (got != 3) $display("FAIL b2b_timeout: got %0d words, required 3", got);
        else n_pass++;
    endtask

    task automatic test_reset_mid_word;
        bit          to;
        logic [31:0] w;
        ar_delay = 0;
        byte_q.push_back({2'b00, 8'h01});
        byte_q.push_back({2'b00, 8'h02});
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (byte_q.size() == 0) break;
        end
        repeat (12) @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (count !== 5'd0 || empty !== 1'b1 || err !== 1'b0 || m_axi_arvalid !== 1'b0)
            $display("FAIL midword_reset: count=%0d empty=%b err=%b arvalid=%b, required 0 1 0 0",
                     count, empty, err, m_axi_arvalid);
        else n_pass++;
        rstn = 1'b1;
        queue_word(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        wait_not_empty(600, to);
        n_total++;
        if (to || count !== 5'd1) $display("FAIL midword_count: timeout=%0d count=%0d, required 0 and 1", to, count);
        else n_pass++;
        pop_word();
        w = exp_q.pop_front();
        n_total++;
        if (dout !== w) $display("FAIL midword_word: got %h, required %h", dout, w);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_pass        = 0;
        n_total       = 0;
        stat_reads    = 0;
        data_reads    = 0;
        ar_delay      = 0;
        slave_en      = 1'b0;
        rstn          = 1'b0;
        re            = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = 32'h0;
        m_axi_rresp   = 2'b00;

        test_reset();
        test_no_data();
        test_single_word();
        test_fill();
        test_error();
        test_back_to_back();
        test_reset_mid_word();

        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d words, required 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
